// File: rtl/pipe_pkg.sv
// Types and constants shared by the decode/execute pipeline register.
// The payload struct order fixes the bit layout held in the skid slots.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd_addr;
    logic            reg_wen;
  } idex_pld_t;

  localparam int PLD_W = $bits(idex_pld_t);

  function automatic idex_pld_t nop_pld();
    idex_pld_t p;
    p         = '0;
    p.inst    = NOP_INST;
    return p;
  endfunction

endpackage

// File: rtl/id_ex_if.sv
// Signal bundle between decode/ctrl and execute around the id_ex register.
// slave is the register's view; master is the surrounding pipeline's view.
interface id_ex_if;
  import pipe_pkg::*;

  logic [XLEN-1:0] inst_i;
  logic [XLEN-1:0] inst_addr_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            reg_wen_i;
  logic            valid_i;
  logic            ready_o;
  logic            flush_i;
  logic            hold_i;

  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] inst_addr_o;
  logic [XLEN-1:0] op1_o;
  logic [XLEN-1:0] op2_o;
  logic [4:0]      rd_addr_o;
  logic            reg_wen_o;
  logic            valid_o;
  logic [31:0]     bubble_cnt_o;

  modport slave (
    input  inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
    input  valid_i, flush_i, hold_i,
    output ready_o,
    output inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o,
    output valid_o, bubble_cnt_o
  );

  modport master (
    output inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
    output valid_i, flush_i, hold_i,
    input  ready_o,
    input  inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o,
    input  valid_o, bubble_cnt_o
  );

endinterface

// File: rtl/skid_buf.sv
// Two-entry skid buffer: main drives the output, skid absorbs one extra push
// so in_ready depends only on the state register.
module skid_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = PLD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_pop,
  output logic [WIDTH-1:0] out_data
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push, pop;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_pop;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            main_d  = in_data;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain into main can happen
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/id_ex.sv
// Decode-to-execute pipeline register: skid buffer plus NOP substitution
// when empty and a saturating bubble-cycle counter.
module id_ex
  import pipe_pkg::*;
(
  input logic  clk,
  input logic  rst,
  id_ex_if.slave bus
);

  idex_pld_t   in_pld, main_pld, out_pld;
  logic        main_valid;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  assign in_pld = '{bus.inst_i, bus.inst_addr_i, bus.op1_i, bus.op2_i,
                    bus.rd_addr_i, bus.reg_wen_i};

  skid_buf #(.WIDTH(PLD_W)) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush_i),
    .in_valid  (bus.valid_i),
    .in_ready  (bus.ready_o),
    .in_data   (in_pld),
    .out_valid (main_valid),
    .out_pop   (~bus.hold_i),
    .out_data  (main_pld)
  );

  // Stale slot contents must never leak to execute while empty
  always_comb begin
    out_pld = main_valid ? main_pld : nop_pld();
    bubble_cnt_d = bubble_cnt_q;
    if (!main_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.inst_o       = out_pld.inst;
  assign bus.inst_addr_o  = out_pld.addr;
  assign bus.op1_o        = out_pld.op1;
  assign bus.op2_o        = out_pld.op2;
  assign bus.rd_addr_o    = out_pld.rd_addr;
  assign bus.reg_wen_o    = out_pld.reg_wen;
  assign bus.valid_o      = main_valid;
  assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex.sv
// Bench for id_ex: scoreboard of pushed PCs checked at every execute pop,
// plus directed checks for reset, hold, flush and counter saturation.
module tb_id_ex;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  id_ex_if bus ();

  id_ex dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic idex_pld_t pld_of(input logic [31:0] pc);
    idex_pld_t p;
    p.inst    = 32'h0000_0033 | (pc << 12);
    p.addr    = pc;
    p.op1     = pc * 3 + 32'd1;
    p.op2     = ~pc;
    p.rd_addr = pc[6:2] ^ 5'd1;
    p.reg_wen = 1'b1;
    return p;
  endfunction

  task automatic drv(input bit v, input logic [31:0] pc, input bit h, input bit f);
    idex_pld_t p;
    p               = pld_of(pc);
    bus.valid_i     = v;
    bus.inst_i      = p.inst;
    bus.inst_addr_i = p.addr;
    bus.op1_i       = p.op1;
    bus.op2_i       = p.op2;
    bus.rd_addr_i   = p.rd_addr;
    bus.reg_wen_i   = p.reg_wen;
    bus.hold_i      = h;
    bus.flush_i     = f;
  endtask

  // One clock: predict push/pop from values settled before the edge
  task automatic step();
    bit          push, pop;
    logic [31:0] exp_pc;
    idex_pld_t   p;
    push = !rst && !bus.flush_i && bus.valid_i && bus.ready_o;
    pop  = bus.valid_o && !bus.hold_i;
    if (rst || bus.flush_i) begin
      sb.delete();
    end else if (pop) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_pc = sb.pop_front();
        p      = pld_of(exp_pc);
        chk("pop_addr", bus.inst_addr_o, p.addr);
        chk("pop_inst", bus.inst_o, p.inst);
        chk("pop_op1", bus.op1_o, p.op1);
        chk("pop_op2", bus.op2_o, p.op2);
        chk("pop_rd", bus.rd_addr_o, p.rd_addr);
        chk("pop_wen", bus.reg_wen_o, p.reg_wen);
      end
    end
    if (push) sb.push_back(bus.inst_addr_i);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_valid"}, bus.valid_o, 0);
    chk({tag, "_inst"}, bus.inst_o, 32'h13);
    chk({tag, "_addr"}, bus.inst_addr_o, 0);
    chk({tag, "_op1"}, bus.op1_o, 0);
    chk({tag, "_wen"}, bus.reg_wen_o, 0);
    chk({tag, "_ready"}, bus.ready_o, 1);
  endtask

  initial begin
    int idx;
    rst = 1'b1;
    drv(0, 32'h0, 0, 0);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    chk_nop("reset");
    chk("reset_bubble", bus.bubble_cnt_o, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("idle_bubble", bus.bubble_cnt_o, i);
    end

    for (int i = 0; i < 3; i++) begin
      drv(1, i * 4, 0, 0);
      step();
      chk("stream_addr", bus.inst_addr_o, i * 4);
      chk("stream_valid", bus.valid_o, 1);
    end
    drv(0, 32'h0, 0, 0);
    step();
    chk("stream_drained", bus.valid_o, 0);

    idx = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      bit h, acc;
      h = (cyc == 1) || (cyc == 2);
      if (idx < 4) drv(1, idx * 4, h, 0);
      else         drv(0, 32'h0, h, 0);
      if (cyc == 2) chk("hold_ready_low", bus.ready_o, 0);
      if (cyc >= 1 && cyc <= 3) begin
        chk("hold_frozen_addr", bus.inst_addr_o, 0);
        chk("hold_frozen_valid", bus.valid_o, 1);
      end
      acc = (idx < 4) && bus.ready_o;
      step();
      if (acc) idx++;
    end
    chk("hold_all_pushed", idx, 4);
    chk("hold_sb_empty", sb.size(), 0);

    drv(1, 32'h20, 1, 0);
    step();
    drv(1, 32'h24, 1, 0);
    step();
    chk("flush_pre_two", bus.ready_o, 0);
    drv(1, 32'h40, 1, 1);
    step();
    chk_nop("flush");
    drv(0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_40", bus.inst_addr_o, 0);
      chk("flush_stay_empty", bus.valid_o, 0);
    end

    drv(1, 32'h50, 1, 0);
    step();
    drv(1, 32'h54, 1, 0);
    step();
    chk("rst_pre_two", bus.ready_o, 0);
    rst = 1'b1;
    drv(0, 32'h0, 1, 0);
    step();
    rst = 1'b0;
    drv(0, 32'h0, 0, 0);
    chk_nop("midrst");
    chk("midrst_bubble", bus.bubble_cnt_o, 0);

    force dut.bubble_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt_q;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_bubble", bus.bubble_cnt_o, 32'hFFFF_FFFF);
    end

    for (int i = 0; i < 8 && sb.size() != 0; i++) step();
    chk("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex.md
# id_ex

Pipeline register between the decode stage and the execute stage of the RV32 core. It captures decoded operands from decode through a valid/ready handshake and presents them to the combinational execute stage. It is a two-entry skid buffer, so `ready_o` toward decode never depends combinationally on `hold_i`. Jump flush and hold come from ctrl. Whenever no instruction is valid, it feeds execute a canonical NOP and counts bubble cycles for performance analysis.

## Interface
- `XLEN`, 32: data/address width.
- `NOP_INST`, 32'h00000013: instruction presented when empty (`addi x0,x0,0`).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `inst_i`, `inst_addr_i`  in  XLEN each: instruction and its PC from decode.
- `op1_i`, `op2_i`  in  XLEN each: decoded operands.
- `rd_addr_i`  in  5: destination register.
- `reg_wen_i`  in  1: register write enable.
- `valid_i`  in  1: decode presents an instruction.
- `ready_o`  out  1: buffer can accept; push = `valid_i & ready_o`.
- `flush_i`  in  1: from ctrl, equal to execute's `jump_en_o`; discard all held and incoming instructions.
- `hold_i`  in  1: from ctrl; execute does not consume this cycle.
- `inst_o`, `inst_addr_o`, `op1_o`, `op2_o`, `rd_addr_o`, `reg_wen_o`  out: payload to execute.
- `valid_o`  out  1: payload is a real instruction.
- `bubble_cnt_o`  out  32: saturating count of cycles with `valid_o==0`.

## Operation
- Payload is 134 bits: inst, addr, op1, op2, rd_addr, reg_wen. It is held in two slots: `main`, which drives the outputs, and `skid`.
- State: EMPTY, ONE, TWO.
  - `valid_o = (state != EMPTY)`.
  - `ready_o = (state != TWO)`.
  - pop = `valid_o & ~hold_i`.
- Transitions, evaluated in priority order:
  1. `rst` -> EMPTY.
  2. `flush_i` -> EMPTY. A push in the same cycle is dropped.
  3. EMPTY, push -> ONE, `main <= in`.
  4. ONE, push & !pop -> TWO, `skid <= in`.
  5. ONE, pop & !push -> EMPTY.
  6. ONE, push & pop -> ONE, `main <= in`.
  7. TWO, pop -> ONE, `main <= skid`. No push is possible in TWO, since `ready_o` is 0.
  8. Otherwise hold. Outputs stay bit-stable while `hold_i` is high.
- In EMPTY, outputs are forced to: `inst_o=NOP_INST`, `inst_addr_o=0`, `op1_o=0`, `op2_o=0`, `rd_addr_o=0`, `reg_wen_o=0`. These values are forced regardless of stale slot contents.
- Bubble counter:
  - Cleared by `rst`.
  - Otherwise increments by 1 each cycle `valid_o==0`.
  - Saturates at 32'hFFFFFFFF with no wrap.
- Order is strictly FIFO. No instruction is duplicated or lost except by flush.

## Timing
- Reset values:
  - `valid_o=0`, `ready_o=1`, `bubble_cnt_o=0`.
  - Payload outputs take the NOP values listed under Operation.
- Latency: push into EMPTY appears on outputs the next cycle.
- Throughput: one instruction per cycle with `hold_i` low.
- `ready_o` is a pure function of the state register and has no combinational path from any input.
- Flush: `valid_o=0` with NOP outputs from the cycle after `flush_i`.
- Hold: with one entry held, one further push is absorbed. `ready_o` then drops the cycle after that second push.
- Simultaneous `flush_i` and `hold_i`: flush wins.
- Reset asserted in any state: EMPTY on the next edge; counter cleared.

## Structure
- Shared package `pipe_pkg`:
  - `NOP_INST` constant.
  - State enum, 2-bit: EMPTY=0, ONE=1, TWO=2.
  - Packed payload struct `idex_pld_t`.
- Sub-module `skid_buf`:
  - Parameters: `WIDTH`.
  - Ports: `clk`, `rst`, `flush`, `in_valid`, `in_ready`, `in_data`, `out_valid`, `out_pop`, `out_data`.
  - `id_ex` wraps it, adds NOP forcing and the bubble counter.
- Expected size: roughly 150-250 lines of RTL.

## Test plan
- Reset: hold `rst` for 2 cycles, then release. Required response:
  - `valid_o=0`, `inst_o=32'h13`, `reg_wen_o=0`, `ready_o=1`.
  - `bubble_cnt_o` reads 0, then 1, 2, 3 on the following idle cycles.
- Streaming: push 3 instructions at PCs 0x0, 0x4, 0x8 on consecutive cycles with `hold_i=0`. Required response: `inst_addr_o` shows 0x0, 0x4, 0x8 on cycles 1-3, with `valid_o=1` throughout.
- Hold: push 4 instructions back-to-back and raise `hold_i` on cycles 1-2. Required response:
  - `ready_o` drops after the second push.
  - Outputs stay frozen on 0x0 during the hold.
  - Then 0x0, 0x4, 0x8, 0xC are delivered in order with none lost.
- Flush: reach state TWO, then assert `flush_i` in the same cycle as `valid_i=1` with PC 0x40. Required response:
  - Next cycle `valid_o=0`, `inst_o=32'h13`, `ready_o=1`.
  - 0x40 never appears on the outputs.
- Reset mid-operation: with state TWO and `hold_i=1`, pulse `rst`. Required response: next cycle EMPTY, NOP outputs, `bubble_cnt_o=0`.
- Counter saturation: force the counter to 32'hFFFFFFFE and leave the block idle for 3 cycles. Required response: `bubble_cnt_o` stays at 32'hFFFFFFFF.
